// File: rtl/exu_wb_arb_pkg.sv
// Shared widths and helpers for the long-latency writeback arbiter.
package exu_wb_arb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RFIDX_DEF = 5;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exu_wb_arb_if.sv
// Channel push, writeback port and hazard-query signals of the writeback arbiter.
interface exu_wb_arb_if #(
  parameter int NCH   = 2,
  parameter int XLEN  = 32,
  parameter int RFIDX = 5
);
  logic [NCH-1:0]       i_ch_vld;
  logic [NCH*RFIDX-1:0] i_ch_rdidx;
  logic [NCH*XLEN-1:0]  i_ch_wdata;
  logic [NCH-1:0]       o_ch_rdy;
  logic                 i_sc_wen;
  logic                 i_kill_vld;
  logic [RFIDX-1:0]     i_kill_rdidx;
  logic [RFIDX-1:0]     i_chk_rdidx;
  logic                 o_pend_match;
  logic [NCH-1:0]       o_busy;
  logic                 o_rdwen;
  logic [RFIDX-1:0]     o_rdidx;
  logic [XLEN-1:0]      o_rdwdata;
  logic [NCH-1:0]       o_gnt;

  modport slave (
    input  i_ch_vld, i_ch_rdidx, i_ch_wdata, i_sc_wen, i_kill_vld, i_kill_rdidx, i_chk_rdidx,
    output o_ch_rdy, o_pend_match, o_busy, o_rdwen, o_rdidx, o_rdwdata, o_gnt
  );

  modport master (
    output i_ch_vld, i_ch_rdidx, i_ch_wdata, i_sc_wen, i_kill_vld, i_kill_rdidx, i_chk_rdidx,
    input  o_ch_rdy, o_pend_match, o_busy, o_rdwen, o_rdidx, o_rdwdata, o_gnt
  );
endinterface

// File: rtl/exu_wb_fifo.sv
// Per-channel result FIFO with live bits, WAW kill and pending-rd lookup.
// Dead heads drain themselves; live heads leave only when granted.
module exu_wb_fifo
  import exu_wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEF,
  parameter int RFIDX = RFIDX_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [RFIDX-1:0] i_push_rdidx,
  input  logic [XLEN-1:0]  i_push_wdata,
  output logic             o_rdy,
  input  logic             i_pop,
  input  logic             i_kill_vld,
  input  logic [RFIDX-1:0] i_kill_rdidx,
  input  logic [RFIDX-1:0] i_chk_rdidx,
  output logic             o_pend_match,
  output logic             o_busy,
  output logic             o_head_live,
  output logic [RFIDX-1:0] o_head_rdidx,
  output logic [XLEN-1:0]  o_head_wdata
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] live_q;
  logic [RFIDX-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             push_s, pop_s, kill_s, push_live_s;
  logic [DEPTH-1:0] kill_hit_s, pend_hit_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign o_rdy        = (cnt_q < CW'(DEPTH));
  assign o_busy       = (cnt_q != '0);
  assign o_head_live  = o_busy & live_q[head_q];
  assign o_head_rdidx = rd_q[head_q];
  assign o_head_wdata = data_q[head_q];
  assign push_s       = i_push & o_rdy;
  assign pop_s        = o_busy & (~live_q[head_q] | i_pop);
  assign kill_s       = i_kill_vld & (i_kill_rdidx != '0);
  assign push_live_s  = (i_push_rdidx != '0) & ~(kill_s & (i_push_rdidx == i_kill_rdidx));
  assign o_pend_match = (|pend_hit_s) & (i_chk_rdidx != '0);

  // Per-entry kill and pending-rd compares against stored state only
  always_comb begin
    kill_hit_s = '0;
    pend_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit_s[i] = kill_s & (rd_q[i] == i_kill_rdidx);
      pend_hit_s[i] = live_q[i] & (rd_q[i] == i_chk_rdidx);
    end
  end

  // Occupancy next-state
  always_comb begin
    cnt_d = cnt_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and live bits; popped slots are cleared so stale rds never match
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      live_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i] <= live_q[i] & ~kill_hit_s[i] & ~(pop_s && (head_q == PW'(i)));
      end
      if (push_s) begin
        live_q[tail_q] <= push_live_s;
        rd_q[tail_q]   <= i_push_rdidx;
        data_q[tail_q] <= i_push_wdata;
        tail_q         <= ptr_inc(tail_q);
      end else begin
        tail_q <= tail_q;
      end
      if (pop_s) begin
        head_q <= ptr_inc(head_q);
      end else begin
        head_q <= head_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exu_wb_arb.sv
// Round-robin writeback arbiter draining NCH long-latency channel FIFOs into
// the shared regfile write port, yielding to the single-cycle path.
module exu_wb_arb
  import exu_wb_arb_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEF,
  parameter int RFIDX = RFIDX_DEF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  exu_wb_arb_if.slave   bus
);

  localparam int PTRW = ptr_width(NCH);

  logic [NCH-1:0]   rdy_s, busy_s, pend_s, cand_s, gnt_s;
  logic [RFIDX-1:0] head_rd_s   [NCH];
  logic [XLEN-1:0]  head_data_s [NCH];
  logic [PTRW-1:0]  ptr_q, ptr_d, gidx_s;
  logic             found_s;
  int               c_v;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    exu_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .RFIDX(RFIDX)) u_fifo (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_push       (bus.i_ch_vld[k]),
      .i_push_rdidx (bus.i_ch_rdidx[k*RFIDX +: RFIDX]),
      .i_push_wdata (bus.i_ch_wdata[k*XLEN +: XLEN]),
      .o_rdy        (rdy_s[k]),
      .i_pop        (gnt_s[k]),
      .i_kill_vld   (bus.i_kill_vld),
      .i_kill_rdidx (bus.i_kill_rdidx),
      .i_chk_rdidx  (bus.i_chk_rdidx),
      .o_pend_match (pend_s[k]),
      .o_busy       (busy_s[k]),
      .o_head_live  (cand_s[k]),
      .o_head_rdidx (head_rd_s[k]),
      .o_head_wdata (head_data_s[k])
    );
  end

  // First live head at or after the RR pointer, unless the single-cycle path owns the port
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    gnt_s   = '0;
    c_v     = 0;
    if (!bus.i_sc_wen) begin
      for (int off = 0; off < NCH; off++) begin
        c_v = int'(ptr_q) + off;
        c_v = (c_v >= NCH) ? (c_v - NCH) : c_v;
        if (!found_s && cand_s[c_v]) begin
          found_s = 1'b1;
          gidx_s  = PTRW'(c_v);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
    if (found_s) begin
      gnt_s[gidx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Pointer moves just past the winner
  always_comb begin
    ptr_d = ptr_q;
    if (found_s) begin
      ptr_d = (gidx_s == PTRW'(NCH - 1)) ? '0 : (gidx_s + PTRW'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign bus.o_ch_rdy     = rdy_s;
  assign bus.o_busy       = busy_s;
  assign bus.o_pend_match = |pend_s;
  assign bus.o_gnt        = gnt_s;
  assign bus.o_rdwen      = found_s;
  assign bus.o_rdidx      = found_s ? head_rd_s[gidx_s] : '0;
  assign bus.o_rdwdata    = found_s ? head_data_s[gidx_s] : '0;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Directed vector bench for exu_wb_arb (NCH=2, DEPTH=2): per-cycle table plus a reset sequence.
module tb_exu_wb_arb;
  import exu_wb_arb_pkg::*;

  localparam int NCH = 2, DEPTH = 2, XLEN = 32, RFIDX = 5;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_err;

  exu_wb_arb_if #(.NCH(NCH), .XLEN(XLEN), .RFIDX(RFIDX)) bus ();

  exu_wb_arb #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN), .RFIDX(RFIDX)) u_dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        sc;
    logic        kv;
    logic [4:0]  krd;
    logic [4:0]  chk;
    logic [1:0]  e_rdy;
    logic [1:0]  e_busy;
    logic        e_wen;
    logic [4:0]  e_rdidx;
    logic [31:0] e_wdata;
    logic [1:0]  e_gnt;
    logic        e_pend;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [1:0] vld, input logic [4:0] rd0, input logic [31:0] d0,
    input logic [4:0] rd1, input logic [31:0] d1, input logic sc, input logic kv,
    input logic [4:0] krd, input logic [4:0] chk, input logic [1:0] e_rdy,
    input logic [1:0] e_busy, input logic e_wen, input logic [4:0] e_rdidx,
    input logic [31:0] e_wdata, input logic [1:0] e_gnt, input logic e_pend);
    vec_t v;
    v.vld = vld; v.rd0 = rd0; v.d0 = d0; v.rd1 = rd1; v.d1 = d1;
    v.sc = sc; v.kv = kv; v.krd = krd; v.chk = chk;
    v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_wen = e_wen; v.e_rdidx = e_rdidx;
    v.e_wdata = e_wdata; v.e_gnt = e_gnt; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_ch_vld     = v.vld;
    bus.i_ch_rdidx   = {v.rd1, v.rd0};
    bus.i_ch_wdata   = {v.d1, v.d0};
    bus.i_sc_wen     = v.sc;
    bus.i_kill_vld   = v.kv;
    bus.i_kill_rdidx = v.krd;
    bus.i_chk_rdidx  = v.chk;
  endtask

  task automatic check_reset_outputs(input int idx);
    chk("rst_rdy",   idx, 64'(bus.o_ch_rdy),     64'(2'b11));
    chk("rst_busy",  idx, 64'(bus.o_busy),       64'(2'b00));
    chk("rst_wen",   idx, 64'(bus.o_rdwen),      64'(1'b0));
    chk("rst_gnt",   idx, 64'(bus.o_gnt),        64'(2'b00));
    chk("rst_pend",  idx, 64'(bus.o_pend_match), 64'(1'b0));
  endtask

  initial begin
    vec_t idle;
    n_chk = 0;
    n_err = 0;
    rstn  = 1'b0;
    idle  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd5,
               2'b11, 2'b00, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0);
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_reset_outputs(0);
    rstn = 1'b1;
    @(negedge clk);

    //        vld    rd0    d0          rd1    d1          sc    kv    krd    chk    rdy    busy   wen   rdidx  wdata        gnt    pend
    vq.push_back(mk(2'b01, 5'd5,  32'hAAAA,   5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd5,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd5,  2'b11, 2'b01, 1'b1, 5'd5,  32'hAAAA,   2'b01, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd5,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b11, 5'd3,  32'h31,     5'd4,  32'h41,     1'b0, 1'b0, 5'd0,  5'd3,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b11, 5'd3,  32'h32,     5'd4,  32'h42,     1'b0, 1'b0, 5'd0,  5'd3,  2'b11, 2'b11, 1'b1, 5'd4,  32'h41,     2'b10, 1'b1));
    vq.push_back(mk(2'b11, 5'd3,  32'h33,     5'd4,  32'h43,     1'b0, 1'b0, 5'd0,  5'd3,  2'b10, 2'b11, 1'b1, 5'd3,  32'h31,     2'b01, 1'b1));
    vq.push_back(mk(2'b11, 5'd3,  32'h34,     5'd4,  32'h44,     1'b0, 1'b0, 5'd0,  5'd4,  2'b01, 2'b11, 1'b1, 5'd4,  32'h42,     2'b10, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd3,  2'b10, 2'b11, 1'b1, 5'd3,  32'h32,     2'b01, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd4,  2'b11, 2'b11, 1'b1, 5'd4,  32'h43,     2'b10, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd3,  2'b11, 2'b01, 1'b1, 5'd3,  32'h34,     2'b01, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd3,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b10, 5'd0,  32'h0,      5'd7,  32'h77,     1'b1, 1'b0, 5'd0,  5'd7,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(2'b00, 5'd0, 32'h0,     5'd0,  32'h0,      1'b1, 1'b0, 5'd0,  5'd7,  2'b11, 2'b10, 1'b0, 5'd0,  32'h0,      2'b00, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd7,  2'b11, 2'b10, 1'b1, 5'd7,  32'h77,     2'b10, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd7,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b01, 5'd9,  32'h99,     5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd9,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b01, 5'd10, 32'h1010,   5'd0,  32'h0,      1'b1, 1'b0, 5'd0,  5'd9,  2'b11, 2'b01, 1'b0, 5'd0,  32'h0,      2'b00, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b1, 1'b1, 5'd9,  5'd9,  2'b10, 2'b01, 1'b0, 5'd0,  32'h0,      2'b00, 1'b1));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd9,  2'b10, 2'b01, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd9,  2'b11, 2'b01, 1'b1, 5'd10, 32'h1010,   2'b01, 1'b0));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd10, 2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b01, 5'd0,  32'h1234,   5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd0,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd0,  2'b11, 2'b01, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd0,  2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b10, 5'd0,  32'h0,      5'd12, 32'hC0C0,   1'b0, 1'b1, 5'd12, 5'd12, 2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd12, 2'b11, 2'b10, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));
    vq.push_back(mk(2'b00, 5'd0,  32'h0,      5'd0,  32'h0,      1'b0, 1'b0, 5'd0,  5'd12, 2'b11, 2'b00, 1'b0, 5'd0,  32'h0,      2'b00, 1'b0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #1;
      chk("rdy",  i, 64'(bus.o_ch_rdy),     64'(vq[i].e_rdy));
      chk("busy", i, 64'(bus.o_busy),       64'(vq[i].e_busy));
      chk("wen",  i, 64'(bus.o_rdwen),      64'(vq[i].e_wen));
      chk("gnt",  i, 64'(bus.o_gnt),        64'(vq[i].e_gnt));
      chk("pend", i, 64'(bus.o_pend_match), 64'(vq[i].e_pend));
      if (vq[i].e_wen) begin
        chk("rdidx", i, 64'(bus.o_rdidx),   64'(vq[i].e_rdidx));
        chk("wdata", i, 64'(bus.o_rdwdata), 64'(vq[i].e_wdata));
      end
      @(negedge clk);
    end

    // Fill both FIFOs while the single-cycle path holds the port, then reset mid-flight
    drive(mk(2'b11, 5'd1, 32'h100, 5'd2, 32'h200, 1'b1, 1'b0, 5'd0, 5'd1,
             2'b11, 2'b00, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0));
    @(negedge clk);
    drive(mk(2'b11, 5'd1, 32'h101, 5'd2, 32'h201, 1'b1, 1'b0, 5'd0, 5'd1,
             2'b11, 2'b00, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0));
    @(negedge clk);
    drive(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 5'd1,
             2'b11, 2'b00, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0));
    #1;
    chk("full_rdy",  100, 64'(bus.o_ch_rdy),     64'(2'b00));
    chk("full_busy", 100, 64'(bus.o_busy),       64'(2'b11));
    chk("full_pend", 100, 64'(bus.o_pend_match), 64'(1'b1));
    #1 rstn = 1'b0;
    bus.i_sc_wen = 1'b0;
    #1 check_reset_outputs(101);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_wen",  200 + i, 64'(bus.o_rdwen), 64'(1'b0));
      chk("post_busy", 200 + i, 64'(bus.o_busy),  64'(2'b00));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
